// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO port arbiters.
// The FIFO data width lives in the shared FIFO define. It is guarded so that
// an existing project-wide definition takes precedence.
`ifndef FIFO_DATA_W
`define FIFO_DATA_W 8
`endif

package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Width of a grant index for n requesters (at least one bit)
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin pick: returns the first asserted request found
// when searching upward from (last_grant + 1), wrapping from NUM_REQ-1 to 0.
// The last granted requester is checked last, so a lone requester still wins.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic               o_found,
  output logic [ID_W-1:0]    o_index
);

  int              w_sum;
  logic [ID_W-1:0] w_cand;

  // Walk the candidates in priority order and latch onto the first hit
  always_comb begin
    o_found = 1'b0;
    o_index = {ID_W{1'b0}};
    w_sum   = 0;
    w_cand  = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum   = int'(i_last_grant) + k;
      w_sum   = (w_sum >= NUM_REQ) ? (w_sum - NUM_REQ) : w_sum;
      w_cand  = ID_W'(w_sum);
      o_index = (!o_found && i_req[w_cand]) ? w_cand : o_index;
      o_found = o_found | i_req[w_cand];
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter: shares one FIFO write port among NUM_REQ
// valid/ready requesters, granting bursts of up to BURST_LEN beats. The FIFO
// write strobe and data are registered, so a beat accepted at one edge is
// written during the following cycle. Acceptance is throttled on the FIFO
// full / almost-full flags so the FIFO can never overflow.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_W    = `FIFO_DATA_W,
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_LEN = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_alm_full,
  output logic                      fifo_wren,
  output logic [DATA_W-1:0]         fifo_wrdata,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e         r_state;
  logic [ID_W-1:0]    r_grant;
  logic [ID_W-1:0]    r_last;
  logic [CNT_W-1:0]   r_burst;
  logic               r_wren;
  logic [DATA_W-1:0]  r_wrdata;

  logic               w_can_accept;
  logic               w_xfer;
  logic               w_cur_valid;
  logic               w_found;
  logic               w_burst_done;
  logic [ID_W-1:0]    w_pick;
  logic [CNT_W-1:0]   w_burst_nxt;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0]  w_beat;

  // With one entry left, a write already in flight would consume it, so
  // almost-full only blocks acceptance while the strobe is high.
  assign w_can_accept = !fifo_full && !(fifo_alm_full && r_wren);

  // Steer ready, valid and data of the granted requester
  always_comb begin
    w_ready     = {NUM_REQ{1'b0}};
    w_beat      = {DATA_W{1'b0}};
    w_cur_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == ID_W'(i)) begin
        w_beat      = req_data[i*DATA_W +: DATA_W];
        w_cur_valid = req_valid[i];
        w_ready[i]  = (r_state == GRANT) && w_can_accept;
      end else begin
        w_ready[i]  = 1'b0;
      end
    end
  end

  assign w_xfer       = |(req_valid & w_ready);
  assign w_burst_nxt  = r_burst + CNT_W'(1);
  assign w_burst_done = (w_burst_nxt == CNT_W'(BURST_LEN));

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req        (req_valid),
    .i_last_grant (r_last),
    .o_found      (w_found),
    .o_index      (w_pick)
  );

  // Arbitration FSM: IDLE picks a requester, GRANT streams a burst, STALL
  // waits for both FIFO flags to clear before resuming the same burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= {ID_W{1'b0}};
      r_last  <= ID_W'(NUM_REQ - 1);
      r_burst <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_burst <= {CNT_W{1'b0}};
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            r_burst <= w_burst_nxt;
            // The last beat wins over a simultaneous full: rotate, not stall
            if (w_burst_done) begin
              r_last  <= r_grant;
              r_state <= IDLE;
            end
          end else if (!w_cur_valid) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end else if (fifo_full) begin
            r_state <= STALL;
          end
        end
        STALL: begin
          if (!fifo_full && !fifo_alm_full) begin
            r_state <= GRANT;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Registered FIFO write port; data holds its last value between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wren   <= 1'b0;
      r_wrdata <= {DATA_W{1'b0}};
    end else begin
      r_wren <= w_xfer;
      if (w_xfer) begin
        r_wrdata <= w_beat;
      end
    end
  end

  assign req_ready   = w_ready;
  assign fifo_wren   = r_wren;
  assign fifo_wrdata = r_wrdata;
  assign grant_id    = r_grant;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a data scoreboard and an 8-deep FIFO
// occupancy model for the flag-throttling scenario.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_alm_full;
  logic             fifo_wren;
  logic [DW-1:0]    fifo_wrdata;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_mem [NR][16];
  int         src_len [NR];
  int         src_pos [NR];
  logic [7:0] sb_q[$];
  int         gnt_log[$];
  bit         model_en;
  int         fifo_cnt;
  int         wr_cnt;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .DATA_W    (DW),
    .NUM_REQ   (NR),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_alm_full (fifo_alm_full),
    .fifo_wren     (fifo_wren),
    .fifo_wrdata   (fifo_wrdata),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_src();
    for (int i = 0; i < NR; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = src_mem[i][src_pos[i]];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = 8'h00;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    apply_src();
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) src_mem[r][k] = base + 8'(k);
    src_len[r] = n;
    src_pos[r] = 0;
  endtask

  task automatic set_flags();
    if (model_en) begin
      fifo_full     = (fifo_cnt >= 8);
      fifo_alm_full = (fifo_cnt >= 7);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"},  32'(req_ready),   32'd0);
    chk({tag, "_wren"},   32'(fifo_wren),   32'd0);
    chk({tag, "_wrdata"}, 32'(fifo_wrdata), 32'd0);
    chk({tag, "_grant"},  32'(grant_id),    32'd0);
    chk({tag, "_busy"},   32'(busy),        32'd0);
  endtask

  // One clock cycle; entered and left at posedge+1 with inputs applied.
  task automatic cyc();
    logic [NR-1:0] hs;
    logic          prev_full;
    logic          wren_before;
    #1;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (model_en && fifo_alm_full && fifo_wren)
      chk("ready_alm_throttle", 32'(req_ready), 32'd0);
    hs = req_valid & req_ready;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        sb_q.push_back(src_mem[i][src_pos[i]]);
        gnt_log.push_back(i);
        src_pos[i]++;
      end
    end
    prev_full   = fifo_full;
    wren_before = fifo_wren;
    @(posedge clk);
    #1;
    if (wren_before) begin
      if (model_en) begin
        chk("model_overflow", 32'(fifo_cnt < 8), 32'd1);
        fifo_cnt++;
      end
      wr_cnt++;
    end
    chk("wren_latency", 32'(fifo_wren), 32'(hs != 0));
    if (fifo_wren) begin
      chk("wren_after_full", 32'(prev_full), 32'd0);
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      else                  chk("wr_data", 32'(fifo_wrdata), 32'(sb_q.pop_front()));
    end
    set_flags();
    apply_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    gnt_log.delete();
    fifo_cnt = 0;
    wr_cnt   = 0;
  endtask

  initial begin
    int exp_id;
    rst           = 1'b1;
    fifo_full     = 1'b0;
    fifo_alm_full = 1'b0;
    model_en      = 1'b0;
    fifo_cnt      = 0;
    wr_cnt        = 0;
    req_valid     = '0;
    req_data      = '0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("init");
    rst = 1'b0;

    // T1: requesters 0 and 3 valid after reset -> 0 first, then 3
    load(0, 1, 8'hA0);
    load(3, 1, 8'hA3);
    apply_src();
    cyc();
    chk("t1_first_grant", 32'(grant_id), 32'd0);
    repeat (8) cyc();
    chk("t1_log_size", 32'(gnt_log.size()), 32'd2);
    chk("t1_log0", 32'(gnt_log[0]), 32'd0);
    chk("t1_log1", 32'(gnt_log[1]), 32'd3);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // T2: lone requester 2 sends three beats then drops valid
    gnt_log.delete();
    src_mem[2][0] = 8'h11;
    src_mem[2][1] = 8'h22;
    src_mem[2][2] = 8'h33;
    src_len[2] = 3;
    src_pos[2] = 0;
    apply_src();
    cyc();
    chk("t2_grant", 32'(grant_id), 32'd2);
    chk("t2_busy_on", 32'(busy), 32'd1);
    repeat (3) cyc();
    chk("t2_busy_mid", 32'(busy), 32'd1);
    cyc();
    chk("t2_busy_off", 32'(busy), 32'd0);
    chk("t2_grant_held", 32'(grant_id), 32'd2);
    repeat (2) cyc();
    chk("t2_log_size", 32'(gnt_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t2_log", 32'(gnt_log[k]), 32'd2);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // T3: all four continuously valid; bursts of four with one bubble each
    clear_src();
    do_reset();
    for (int r = 0; r < NR; r++) load(r, 5, 8'(r * 16));
    apply_src();
    repeat (20) cyc();
    chk("t3_beats_in_20", 32'(gnt_log.size()), 32'd16);
    repeat (15) cyc();
    chk("t3_log_size", 32'(gnt_log.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      exp_id = (k < 16) ? (k / 4) : (k - 16);
      chk("t3_order", 32'(gnt_log[k]), 32'(exp_id));
    end
    chk("t3_writes", 32'(wr_cnt), 32'd20);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // T4: full mid-burst -> stall, alm_full hysteresis, resume and rotate
    clear_src();
    do_reset();
    load(1, 4, 8'h50);
    load(2, 1, 8'h60);
    apply_src();
    cyc();
    chk("t4_grant", 32'(grant_id), 32'd1);
    repeat (2) cyc();
    fifo_full = 1'b1;
    #1;
    chk("t4_full_ready", 32'(req_ready), 32'd0);
    cyc();
    fifo_full     = 1'b0;
    fifo_alm_full = 1'b1;
    repeat (3) begin
      cyc();
      #1;
      chk("t4_alm_stall", 32'(req_ready), 32'd0);
      chk("t4_stall_busy", 32'(busy), 32'd1);
    end
    fifo_alm_full = 1'b0;
    cyc();
    #1;
    chk("t4_resume_ready", 32'(req_ready), 32'b0010);
    repeat (10) cyc();
    chk("t4_log_size", 32'(gnt_log.size()), 32'd5);
    for (int k = 0; k < 4; k++) chk("t4_log_burst", 32'(gnt_log[k]), 32'd1);
    chk("t4_log_rotate", 32'(gnt_log[4]), 32'd2);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // T5: 8-deep FIFO with no reads -> exactly eight writes
    clear_src();
    fifo_full     = 1'b0;
    fifo_alm_full = 1'b0;
    do_reset();
    model_en = 1'b1;
    set_flags();
    for (int r = 0; r < NR; r++) load(r, 4, 8'(128 + r * 16));
    apply_src();
    repeat (40) cyc();
    chk("t5_writes", 32'(wr_cnt), 32'd8);
    chk("t5_model_cnt", 32'(fifo_cnt), 32'd8);
    chk("t5_full", 32'(fifo_full), 32'd1);
    #1;
    chk("t5_ready_blocked", 32'(req_ready), 32'd0);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    model_en      = 1'b0;
    fifo_full     = 1'b0;
    fifo_alm_full = 1'b0;

    // T6: async reset right after beat 1 of a burst to requester 3
    clear_src();
    do_reset();
    load(3, 4, 8'hC0);
    apply_src();
    cyc();
    chk("t6_grant", 32'(grant_id), 32'd3);
    cyc();
    chk("t6_wren_before_rst", 32'(fifo_wren), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs("t6_async");
    load(1, 1, 8'hD1);
    load(2, 1, 8'hD2);
    apply_src();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    gnt_log.delete();
    cyc();
    chk("t6_first_grant", 32'(grant_id), 32'd1);
    repeat (20) cyc();
    chk("t6_log_size", 32'(gnt_log.size()), 32'd5);
    chk("t6_log0", 32'(gnt_log[0]), 32'd1);
    chk("t6_log1", 32'(gnt_log[1]), 32'd2);
    for (int k = 2; k < 5; k++) chk("t6_log_tail", 32'(gnt_log[k]), 32'd3);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
